sample_rle: RTL and testbench
=============================

SAMPLE_RLE -- requirements
Module: sample_rle

Interface
REQ-001 The block SHALL have parameter DSIZE, default 32, sample width matching the upstream capture stream.
REQ-002 The block SHALL have parameter CNT_W, default 16, run-count field width; legal range 2..32.
REQ-003 The block SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port enable  in  1  level; 0 stalls input acceptance, state held.
REQ-006 The block SHALL have port flush  in  1  single-cycle pulse; request to emit the open run as the final word.
REQ-007 The block SHALL have port s_tdata  in  DSIZE  input sample stream data.
REQ-008 The block SHALL have port s_tvalid  in  1  input sample valid.
REQ-009 The block SHALL have port s_tready  out  1  input ready.
REQ-010 The block SHALL have port m_tdata  out  CNT_W+DSIZE  output word {count[CNT_W-1:0], value[DSIZE-1:0]}.
REQ-011 The block SHALL have port m_tvalid  out  1  output valid.
REQ-012 The block SHALL have port m_tready  in  1  output ready.
REQ-013 The block SHALL have port m_tlast  out  1  marks the word produced by a flush.
REQ-014 The block SHALL have port busy  out  1  run open, output word pending or flush pending.

Function
REQ-015 States SHALL be IDLE (no run held) and RUN (value cur, count cnt in 1..2^CNT_W-1 held).
REQ-016 Output register SHALL be free when !m_tvalid || m_tready; s_tready SHALL equal enable && !flush_pend && free.
REQ-017 Sample acceptance SHALL be s_tvalid && s_tready at a rising edge.
REQ-018 IDLE + accept: cur<=s_tdata, cnt<=1, go RUN; no output.
REQ-019 RUN + accept, s_tdata==cur and cnt<2^CNT_W-1: cnt<=cnt+1; no output.
REQ-020 RUN + accept, mismatch or cnt saturated: output register<={cnt,cur}, m_tlast=0; cur<=s_tdata, cnt<=1.
REQ-021 Emitted words SHALL assert m_tvalid on the cycle after the accepting edge (latency 1); m_tdata/m_tlast SHALL stay stable while m_tvalid && !m_tready.
REQ-022 A flush pulse SHALL set flush_pend; while flush_pend, when free: in RUN emit {cnt,cur} with m_tlast=1, go IDLE; in IDLE emit nothing; then clear flush_pend.
REQ-023 A flush pulse arriving while flush_pend is already set SHALL be absorbed (single final word).
REQ-024 Flush in the same cycle as an accepted sample: the sample SHALL be processed first; the flush takes effect on following cycles.
REQ-025 m_tvalid SHALL clear on m_tvalid && m_tready unless a new word is loaded the same edge.
REQ-026 Counts SHALL never wrap; a saturated run splits into consecutive words.

Reset
REQ-027 On reset: state IDLE, cnt 0, cur 0, flush_pend 0, m_tvalid 0, m_tdata 0, m_tlast 0, busy 0; s_tready = enable on the first cycle after reset.
REQ-028 Reset mid-run or with a pending output word SHALL discard both without emission.

Configuration
REQ-029 With SAMPLE_RLE_STATS_EN defined: outputs stat_in (32 bits, accepted samples) and stat_out (32 bits, emitted words) SHALL exist, SHALL saturate at 2^32-1 and SHALL clear on reset.
REQ-030 Without SAMPLE_RLE_STATS_EN: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 The shared package logicap_pkg SHALL hold the RLE state enum and the default CNT_W constant.
REQ-032 The output register/handshake SHALL be the sub-module rle_out_reg; run tracking SHALL stay in sample_rle.

Verification
REQ-033 Accept 5×0xA, then 0xB, then flush, m_tready=1 -> words {5,0xA} tlast=0, then {1,0xB} tlast=1.
REQ-034 CNT_W=2, accept 7×0x3, then flush -> {3,0x3}, {3,0x3}, {1,0x3} tlast=1.
REQ-035 m_tready=0 with word pending -> s_tready=0 and m_tdata stable for 10 cycles; release -> one handshake, s_tready=1 next cycle.
REQ-036 Flush in IDLE -> no m_tvalid, busy=0 after 1 cycle; flush same cycle as accepted 0x7 in IDLE -> {1,0x7} tlast=1.
REQ-037 Reset asserted during RUN (cnt=4) and with m_tvalid=1 -> m_tvalid=0, busy=0 next cycle, no word emitted.
REQ-038 With SAMPLE_RLE_STATS_EN: 9 accepts, 3 words -> stat_in=9, stat_out=3.

Source files
------------

// File: rtl/logicap_pkg.sv
// Shared definitions for the logic-capture blocks.
// Holds the run-length encoder state type and the default run-count width.
package logicap_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rle_state_t;

    localparam int RLE_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/rle_out_reg.sv
// Output holding register for the run-length encoder.
// A loaded word stays stable until the downstream handshake completes.
module rle_out_reg #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             m_tready,
    output logic             free,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast
);

    assign free = !m_tvalid || m_tready;

    // The caller only loads when free, so a load may overlap the handshake of the previous word
    always_ff @(posedge clk) begin
        if (reset) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tdata  <= load_data;
            m_tlast  <= load_last;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_rle.sv
// Run-length encoder for a capture sample stream, emitting {count, value} words.
// Define SAMPLE_RLE_STATS_EN to add saturating stat_in/stat_out counters.
module sample_rle
    import logicap_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int CNT_W = RLE_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [DSIZE-1:0]       s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [CNT_W+DSIZE-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy
`ifdef SAMPLE_RLE_STATS_EN
    ,
    output logic [31:0]            stat_in,
    output logic [31:0]            stat_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rle_state_t               state;
    logic [DSIZE-1:0]         cur;
    logic [CNT_W-1:0]         cnt;
    logic                     flush_pend;
    logic                     free;
    logic                     accept;
    logic                     do_flush;
    logic                     load;
    logic                     load_last;
    logic [CNT_W+DSIZE-1:0]   load_data;

    assign s_tready = enable && !flush_pend && free;
    assign accept   = s_tvalid && s_tready;
    assign do_flush = enable && flush_pend && free;
    assign busy     = (state == RUN) || m_tvalid || flush_pend;

    // A run closes on a differing or overflowing sample, or when a pending flush finds the output free
    always_comb begin
        load      = 1'b0;
        load_last = 1'b0;
        load_data = {cnt, cur};
        if (accept && state == RUN && (s_tdata != cur || cnt == CNT_MAX)) begin
            load = 1'b1;
        end else if (do_flush && state == RUN) begin
            load      = 1'b1;
            load_last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (accept) begin
                if (state == IDLE || load) begin
                    cur   <= s_tdata;
                    cnt   <= CNT_W'(1);
                    state <= RUN;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (do_flush) begin
                state <= IDLE;
                cnt   <= '0;
            end
            // A second flush while one is pending is absorbed
            if (flush_pend) begin
                flush_pend <= !do_flush;
            end else begin
                flush_pend <= flush;
            end
        end
    end

    rle_out_reg #(
        .WIDTH(CNT_W + DSIZE)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .load_last(load_last),
        .m_tready (m_tready),
        .free     (free),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast)
    );

`ifdef SAMPLE_RLE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_in  <= '0;
            stat_out <= '0;
        end else begin
            if (accept && stat_in != '1) begin
                stat_in <= stat_in + 32'd1;
            end
            if (m_tvalid && m_tready && stat_out != '1) begin
                stat_out <= stat_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_rle.sv
// Self-checking bench for sample_rle: directed scenarios plus randomized segments
// scored against a run-length encoding of the accepted sample sequence.
module tb_sample_rle;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [11:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;

    logic        b_enable;
    logic        b_flush;
    logic [7:0]  b_s_tdata;
    logic        b_s_tvalid;
    logic        b_s_tready;
    logic [9:0]  b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tready;
    logic        b_m_tlast;
    logic        b_busy;

`ifdef SAMPLE_RLE_STATS_EN
    logic [31:0] stat_in;
    logic [31:0] stat_out;
    logic [31:0] b_stat_in;
    logic [31:0] b_stat_out;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  seg[$];
    logic [31:0] obs[$];
    logic [31:0] obs_b[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sample_rle #(.DSIZE(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .flush   (flush),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .busy    (busy)
`ifdef SAMPLE_RLE_STATS_EN
        ,
        .stat_in (stat_in),
        .stat_out(stat_out)
`endif
    );

    sample_rle #(.DSIZE(8), .CNT_W(2)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .enable  (b_enable),
        .flush   (b_flush),
        .s_tdata (b_s_tdata),
        .s_tvalid(b_s_tvalid),
        .s_tready(b_s_tready),
        .m_tdata (b_m_tdata),
        .m_tvalid(b_m_tvalid),
        .m_tready(b_m_tready),
        .m_tlast (b_m_tlast),
        .busy    (b_busy)
`ifdef SAMPLE_RLE_STATS_EN
        ,
        .stat_in (b_stat_in),
        .stat_out(b_stat_out)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge; handshakes are recorded 1 time unit later
    task automatic cycle();
        #1;
        if (!reset) begin
            if (s_tvalid && s_tready) seg.push_back(s_tdata);
            if (m_tvalid && m_tready) obs.push_back({19'd0, m_tlast, m_tdata});
            if (b_m_tvalid && b_m_tready) obs_b.push_back({21'd0, b_m_tlast, b_m_tdata});
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
        s_tvalid = v;
        s_tdata  = d;
        flush    = f;
        cycle();
    endtask

    // Reference: group equal samples into runs, split runs at the count limit, mark the final word
    task automatic buildExpected(input int cmax);
        int i;
        int j;
        int len;
        int n;
        logic [31:0] tmp;
        exp_q.delete();
        i = 0;
        while (i < seg.size()) begin
            j = i;
            while (j < seg.size() && seg[j] == seg[i]) j++;
            len = j - i;
            while (len > 0) begin
                n = (len > cmax) ? cmax : len;
                exp_q.push_back({19'd0, 1'b0, 4'(n), seg[i]});
                len -= n;
            end
            i = j;
        end
        if (exp_q.size() > 0) begin
            tmp = exp_q.pop_back();
            tmp[12] = 1'b1;
            exp_q.push_back(tmp);
        end
    endtask

    task automatic drainAndCompare(input string tag);
        int waited;
        flush    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        enable   = 1'b1;
        waited   = 0;
        while (busy && waited < 100) begin
            cycle();
            waited++;
        end
        checkOutput({tag, " drained"}, 32'(busy), 32'd0);
        buildExpected(15);
        checkOutput({tag, " word count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            checkOutput($sformatf("%s word%0d", tag, k),
                        (k < obs.size()) ? obs[k] : 32'hFFFF_FFFF, exp_q[k]);
        end
        seg.delete();
        obs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] cur_val;
        int         len;

        reset = 1'b1;  enable = 1'b1;  flush = 1'b0;  s_tdata = '0;  s_tvalid = 1'b0;  m_tready = 1'b1;
        b_enable = 1'b1;  b_flush = 1'b0;  b_s_tdata = '0;  b_s_tvalid = 1'b0;  b_m_tready = 1'b1;
        cycle();
        cycle();
        checkOutput("reset m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("reset m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("reset m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
`ifdef SAMPLE_RLE_STATS_EN
        checkOutput("reset stat_in", stat_in, 32'd0);
        checkOutput("reset stat_out", stat_out, 32'd0);
`endif
        reset = 1'b0;
        #1;
        checkOutput("post-reset s_tready", 32'(s_tready), 32'd1);
        enable = 1'b0;
        #1;
        checkOutput("disabled s_tready", 32'(s_tready), 32'd0);
        enable = 1'b1;
        cycle();

        // Five equal samples, a new value, then flush
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'h0A, 1'b0);
        applyStimulus(1'b1, 8'h0B, 1'b0);
        checkOutput("run5 valid latency", 32'(m_tvalid), 32'd1);
        checkOutput("run5 data", 32'(m_tdata), 32'h50A);
        checkOutput("run5 last", 32'(m_tlast), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("run5 valid cleared", 32'(m_tvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("flush word valid", 32'(m_tvalid), 32'd1);
        checkOutput("flush word data", 32'(m_tdata), 32'h10B);
        checkOutput("flush word last", 32'(m_tlast), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("after flush busy", 32'(busy), 32'd0);
        drainAndCompare("run5");

        // Saturating runs on the 2-bit count instance
        for (int k = 0; k < 7; k++) begin
            b_s_tvalid = 1'b1;
            b_s_tdata  = 8'h03;
            cycle();
        end
        b_s_tvalid = 1'b0;
        b_flush    = 1'b1;
        cycle();
        b_flush = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        checkOutput("sat word count", 32'(obs_b.size()), 32'd3);
        checkOutput("sat word0", (obs_b.size() > 0) ? obs_b[0] : 32'hFFFF_FFFF, 32'h303);
        checkOutput("sat word1", (obs_b.size() > 1) ? obs_b[1] : 32'hFFFF_FFFF, 32'h303);
        checkOutput("sat word2", (obs_b.size() > 2) ? obs_b[2] : 32'hFFFF_FFFF, 32'h503);
        checkOutput("sat busy", 32'(b_busy), 32'd0);

        // Backpressure holds the word and blocks input
        m_tready = 1'b0;
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        checkOutput("stall valid", 32'(m_tvalid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'h03, 1'b0);
            checkOutput($sformatf("stall s_tready %0d", k), 32'(s_tready), 32'd0);
            checkOutput($sformatf("stall m_tdata %0d", k), 32'(m_tdata), 32'h101);
        end
        m_tready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("release valid", 32'(m_tvalid), 32'd0);
        checkOutput("release s_tready", 32'(s_tready), 32'd1);
        checkOutput("release handshakes", 32'(obs.size()), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        drainAndCompare("stall");

        // Flush while idle, then flush together with the first sample
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("idle flush valid", 32'(m_tvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("idle flush valid2", 32'(m_tvalid), 32'd0);
        checkOutput("idle flush busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 8'h07, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("same-cycle valid", 32'(m_tvalid), 32'd1);
        checkOutput("same-cycle data", 32'(m_tdata), 32'h107);
        checkOutput("same-cycle last", 32'(m_tlast), 32'd1);
        drainAndCompare("same-cycle");

        // Back-to-back flush pulses produce a single final word
        m_tready = 1'b0;
        applyStimulus(1'b1, 8'h05, 1'b0);
        applyStimulus(1'b1, 8'h06, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        drainAndCompare("double flush");

        // Reset during an open run discards it
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'h09, 1'b0);
        checkOutput("run4 busy", 32'(busy), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset run valid", 32'(m_tvalid), 32'd0);
        checkOutput("reset run busy", 32'(busy), 32'd0);
        reset = 1'b0;
        seg.delete();
        obs.delete();
        applyStimulus(1'b0, 8'h00, 1'b1);
        drainAndCompare("reset run");

        // Reset with an undelivered word discards it
        m_tready = 1'b0;
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        checkOutput("pending valid", 32'(m_tvalid), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset pending valid", 32'(m_tvalid), 32'd0);
        checkOutput("reset pending busy", 32'(busy), 32'd0);
        reset = 1'b0;
        seg.delete();
        obs.delete();
        m_tready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        drainAndCompare("reset pending");

`ifdef SAMPLE_RLE_STATS_EN
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'h0A + 8'(k / 3), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        drainAndCompare("stats");
        checkOutput("stat_in", stat_in, 32'd9);
        checkOutput("stat_out", stat_out, 32'd3);
`endif

        // Randomized segments with stalls, enable gaps and long runs
        cur_val = 8'h00;
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(30, 120);
            for (int c = 0; c < len; c++) begin
                enable   = ($urandom_range(0, 7) != 0);
                m_tready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) cur_val = 8'($urandom_range(0, 3));
                applyStimulus($urandom_range(0, 4) != 0, cur_val, 1'b0);
            end
            applyStimulus($urandom_range(0, 1) != 0, cur_val, 1'b1);
            drainAndCompare($sformatf("random%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
